// File: rtl/interrupt_sequencer_if.sv
// Data-memory port owned by the interrupt sequencer while it is busy.
//   master : sequencer side (drives request, address, write data)
//   slave  : memory side (drives ack and read data)
// Signals:
//   o_mem_req    request valid, held until acknowledged
//   o_mem_we     1 = write, 0 = read
//   o_mem_addr   word address
//   o_mem_wdata  write data
//   i_mem_ack    memory completed the current request
//   i_mem_rdata  read data, valid with i_mem_ack on reads
interface interrupt_sequencer_if #(
    parameter int ADDR_W = 11
);
    logic              o_mem_req;
    logic              o_mem_we;
    logic [ADDR_W-1:0] o_mem_addr;
    logic [15:0]       o_mem_wdata;
    logic              i_mem_ack;
    logic [15:0]       i_mem_rdata;

    modport master (
        output o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        input  i_mem_ack, i_mem_rdata
    );

    modport slave (
        input  o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata,
        output i_mem_ack, i_mem_rdata
    );
endinterface

// File: rtl/interrupt_sequencer.sv
// Interrupt entry / return-from-interrupt sequencer for the pipelined CPU.
// Entry: drain execute-memory, push PC hi/lo and flags, read the handler
// vector, redirect the PC. RTI: drain, pop flags, PC lo, PC hi, reload.
// Ports:
//   i_clk, i_reset      clock, asynchronous active-low reset
//   mem                 data-memory port (master side)
//   i_interrupt         interrupt request level (rising edge sets pending)
//   i_rti               RTI reached execute-memory (pulse)
//   i_exm_busy          execute-memory has an op in flight
//   i_ret_pc, i_flags   return PC and {C,N,Z} captured when the drain ends
//   i_sp                stack pointer (next free word, grows down)
//   o_busy, o_stall     sequencer active / hold front-end buffers
//   o_flush             clear front-end buffers
//   o_sp_wr, o_sp_next  stack pointer update (pulse)
//   o_pc_load, o_pc_value        PC redirect (pulse) and target
//   o_flags_load, o_flags_value  flags restore (pulse) and value
//   o_int_ack           handler PC loaded (pulse)
module interrupt_sequencer #(
    parameter int ADDR_W      = 11,
    parameter int VECTOR_ADDR = 2
) (
    input  logic                        i_clk,
    input  logic                        i_reset,
    interrupt_sequencer_if.master       mem,
    input  logic                        i_interrupt,
    input  logic                        i_rti,
    input  logic                        i_exm_busy,
    input  logic [31:0]                 i_ret_pc,
    input  logic [2:0]                  i_flags,
    input  logic [ADDR_W-1:0]           i_sp,
    output logic                        o_busy,
    output logic                        o_stall,
    output logic                        o_flush,
    output logic                        o_sp_wr,
    output logic [ADDR_W-1:0]           o_sp_next,
    output logic                        o_pc_load,
    output logic [31:0]                 o_pc_value,
    output logic                        o_flags_load,
    output logic [2:0]                  o_flags_value,
    output logic                        o_int_ack
);
    typedef enum logic [3:0] {
        IDLE, DRAIN, PUSH_HI, PUSH_LO, PUSH_FLAGS, VEC_LO, VEC_HI, LOAD,
        POP_FLAGS, POP_LO, POP_HI, RLOAD
    } state_t;

    state_t      state;
    logic        int_q;
    logic        pending;
    logic        rti_req;
    logic        serve_rti;     // request chosen when leaving IDLE
    logic [31:0] cap_pc;
    logic [2:0]  cap_flags;
    logic [15:0] pc_lo_buf;     // low half of vector / popped PC
    logic [2:0]  flag_buf;      // popped flags until RLOAD

    logic int_edge;
    logic drain_exit;
    logic ack;

    assign int_edge   = i_interrupt & ~int_q;
    assign drain_exit = (state == DRAIN) && !i_exm_busy;
    assign ack        = mem.i_mem_ack;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state         <= IDLE;
            int_q         <= 1'b0;
            pending       <= 1'b0;
            rti_req       <= 1'b0;
            serve_rti     <= 1'b0;
            cap_pc        <= '0;
            cap_flags     <= '0;
            pc_lo_buf     <= '0;
            flag_buf      <= '0;
            o_pc_value    <= '0;
            o_flags_value <= '0;
        end else begin
            int_q <= i_interrupt;
            case (state)
                IDLE: begin
                    // i_rti is looked at directly so RTI needs no capture cycle
                    if (rti_req || i_rti || pending) begin
                        state     <= DRAIN;
                        serve_rti <= rti_req | i_rti;
                    end
                end
                DRAIN: begin
                    if (!i_exm_busy) begin
                        cap_pc    <= i_ret_pc;
                        cap_flags <= i_flags;
                        state     <= serve_rti ? POP_FLAGS : PUSH_HI;
                    end
                end
                PUSH_HI:    if (ack) state <= PUSH_LO;
                PUSH_LO:    if (ack) state <= PUSH_FLAGS;
                PUSH_FLAGS: if (ack) state <= VEC_LO;
                VEC_LO: begin
                    if (ack) begin
                        pc_lo_buf <= mem.i_mem_rdata;
                        state     <= VEC_HI;
                    end
                end
                VEC_HI: begin
                    if (ack) begin
                        o_pc_value <= {mem.i_mem_rdata, pc_lo_buf};
                        state      <= LOAD;
                    end
                end
                LOAD: state <= IDLE;
                POP_FLAGS: begin
                    if (ack) begin
                        flag_buf <= mem.i_mem_rdata[2:0];
                        state    <= POP_LO;
                    end
                end
                POP_LO: begin
                    if (ack) begin
                        pc_lo_buf <= mem.i_mem_rdata;
                        state     <= POP_HI;
                    end
                end
                POP_HI: begin
                    if (ack) begin
                        o_pc_value    <= {mem.i_mem_rdata, pc_lo_buf};
                        o_flags_value <= flag_buf;
                        state         <= RLOAD;
                    end
                end
                RLOAD:   state <= IDLE;
                default: state <= IDLE;
            endcase

            // Clear the served request, but a new request in the same cycle wins.
            if (drain_exit && !serve_rti) pending <= 1'b0;
            if (int_edge)                 pending <= 1'b1;
            if (drain_exit && serve_rti)  rti_req <= 1'b0;
            if (i_rti)                    rti_req <= 1'b1;
        end
    end

    logic is_push;
    logic is_pop;

    always_comb begin
        mem.o_mem_req   = 1'b0;
        mem.o_mem_we    = 1'b0;
        mem.o_mem_addr  = '0;
        mem.o_mem_wdata = '0;
        is_push         = 1'b0;
        is_pop          = 1'b0;
        case (state)
            PUSH_HI:    begin is_push = 1'b1; mem.o_mem_wdata = cap_pc[31:16]; end
            PUSH_LO:    begin is_push = 1'b1; mem.o_mem_wdata = cap_pc[15:0]; end
            PUSH_FLAGS: begin is_push = 1'b1; mem.o_mem_wdata = {13'b0, cap_flags}; end
            VEC_LO: begin
                mem.o_mem_req  = 1'b1;
                mem.o_mem_addr = ADDR_W'(VECTOR_ADDR);
            end
            VEC_HI: begin
                mem.o_mem_req  = 1'b1;
                mem.o_mem_addr = ADDR_W'(VECTOR_ADDR + 1);
            end
            POP_FLAGS, POP_LO, POP_HI: is_pop = 1'b1;
            default: ;
        endcase
        if (is_push) begin
            mem.o_mem_req  = 1'b1;
            mem.o_mem_we   = 1'b1;
            mem.o_mem_addr = i_sp;
        end
        if (is_pop) begin
            mem.o_mem_req  = 1'b1;
            mem.o_mem_addr = i_sp + ADDR_W'(1);
        end
    end

    always_comb begin
        o_busy       = (state != IDLE);
        o_stall      = (state != IDLE);
        o_flush      = (state == DRAIN) || (state == LOAD) || (state == RLOAD);
        o_pc_load    = (state == LOAD) || (state == RLOAD);
        o_int_ack    = (state == LOAD);
        o_flags_load = (state == RLOAD);
        o_sp_wr      = (is_push || is_pop) && ack;
        o_sp_next    = '0;
        if (is_push && ack) o_sp_next = i_sp - ADDR_W'(1);
        if (is_pop && ack)  o_sp_next = i_sp + ADDR_W'(1);
    end
endmodule

// File: tb/tb_interrupt_sequencer.sv
module tb_interrupt_sequencer;
    localparam int ADDR_W = 11;

    logic              clk;
    logic              rst_n;
    logic              i_interrupt, i_rti, i_exm_busy;
    logic [31:0]       i_ret_pc;
    logic [2:0]        i_flags;
    logic [ADDR_W-1:0] sp;
    logic              o_busy, o_stall, o_flush, o_sp_wr, o_pc_load;
    logic              o_flags_load, o_int_ack;
    logic [ADDR_W-1:0] o_sp_next;
    logic [31:0]       o_pc_value;
    logic [2:0]        o_flags_value;

    interrupt_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

    interrupt_sequencer #(.ADDR_W(ADDR_W), .VECTOR_ADDR(2)) dut (
        .i_clk(clk), .i_reset(rst_n), .mem(bus),
        .i_interrupt(i_interrupt), .i_rti(i_rti), .i_exm_busy(i_exm_busy),
        .i_ret_pc(i_ret_pc), .i_flags(i_flags), .i_sp(sp),
        .o_busy(o_busy), .o_stall(o_stall), .o_flush(o_flush),
        .o_sp_wr(o_sp_wr), .o_sp_next(o_sp_next),
        .o_pc_load(o_pc_load), .o_pc_value(o_pc_value),
        .o_flags_load(o_flags_load), .o_flags_value(o_flags_value),
        .o_int_ack(o_int_ack)
    );

    // memory model: ack after wait_n extra cycles, combinational read data
    logic [15:0] memory [0:2047];
    int          cnt, wait_n;
    logic [31:0] wlog[$];
    logic [15:0] rlog[$];
    assign bus.i_mem_ack   = bus.o_mem_req && (cnt >= wait_n);
    assign bus.i_mem_rdata = memory[bus.o_mem_addr];

    int passed, total;
    int drain_cyc, req_cyc, unstable, stall_drop, loads;
    logic              s_wr, s_req, s_ack, s_we, p_req, p_ack;
    logic [ADDR_W-1:0] s_next, s_addr;
    logic [15:0]       s_wdata;
    logic [27:0]       p_bus;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock: sample at negedge, update the SP/memory fixtures after the edge.
    task automatic tick();
        @(negedge clk);
        s_wr = o_sp_wr; s_next = o_sp_next;
        s_req = bus.o_mem_req; s_ack = bus.i_mem_ack; s_we = bus.o_mem_we;
        s_addr = bus.o_mem_addr; s_wdata = bus.o_mem_wdata;
        if (o_busy && !o_stall) stall_drop++;
        if (o_flush && !o_pc_load) drain_cyc++;
        if (s_req) req_cyc++;
        if (s_req && p_req && !p_ack && ({s_we, s_addr, s_wdata} != p_bus)) unstable++;
        if (o_pc_load) loads++;
        p_req = s_req; p_ack = s_ack; p_bus = {s_we, s_addr, s_wdata};
        @(posedge clk);
        #1;
        if (s_wr) sp = s_next;
        if (s_req && s_ack && s_we) begin
            memory[s_addr] = s_wdata;
            wlog.push_back({5'b0, s_addr, s_wdata});
        end
        if (s_req && s_ack && !s_we) rlog.push_back({5'b0, s_addr});
        cnt = (!s_req || s_ack) ? 0 : cnt + 1;
        #1;
    endtask

    task automatic wait_load(output int k);
        k = 0;
        do begin
            tick();
            k++;
        end while (!o_pc_load && k < 60);
    endtask

    int k, d0, r0, l0;

    initial begin
        for (int i = 0; i < 2048; i++) memory[i] = 16'h0;
        memory[2] = 16'h0100;
        memory[3] = 16'h0000;
        passed = 0; total = 0; cnt = 0; wait_n = 0;
        drain_cyc = 0; req_cyc = 0; unstable = 0; stall_drop = 0; loads = 0;
        p_req = 0; p_ack = 0; p_bus = '0;
        rst_n = 0; i_interrupt = 0; i_rti = 0; i_exm_busy = 0;
        i_ret_pc = 0; i_flags = 0; sp = 11'h7FF;
        tick(); tick();
        check("rst_ctl", {o_busy, o_stall, o_flush, bus.o_mem_req, bus.o_mem_we, o_sp_wr,
                          o_pc_load, o_flags_load, o_int_ack}, 0);
        check("rst_data", {bus.o_mem_addr, bus.o_mem_wdata, o_sp_next, o_flags_value}, 0);
        check("rst_pc", o_pc_value, 0);
        rst_n = 1;
        tick();

        // interrupt entry, zero wait
        i_ret_pc = 32'h0001_0040; i_flags = 3'b101;
        i_interrupt = 1;
        wait_load(k);
        check("entry_latency", k, 8);
        check("entry_ack", {o_int_ack, o_flags_load, o_flush}, 3'b101);
        check("entry_pc", o_pc_value, 32'h0000_0100);
        check("entry_nwrites", wlog.size(), 3);
        check("entry_w0", wlog[0], 32'h07FF_0001);
        check("entry_w1", wlog[1], 32'h07FE_0040);
        check("entry_w2", wlog[2], 32'h07FD_0005);
        check("entry_sp", sp, 11'h7FC);
        i_interrupt = 0;
        tick();
        check("entry_pulse_end", {o_pc_load, o_int_ack, o_busy}, 0);

        // RTI
        rlog.delete();
        i_rti = 1;
        tick();
        i_rti = 0;
        wait_load(k);
        check("rti_latency", k + 1, 5);
        check("rti_loads", {o_flags_load, o_int_ack}, 2'b10);
        check("rti_flags", o_flags_value, 3'b101);
        check("rti_pc", o_pc_value, 32'h0001_0040);
        check("rti_reads", {rlog[0], rlog[1], rlog[2]}, 48'h07FD_07FE_07FF);
        check("rti_sp", sp, 11'h7FF);
        tick();

        // drain wait and memory wait states
        wlog.delete();
        wait_n = 2; i_exm_busy = 1;
        i_ret_pc = 32'h1234_5678; i_flags = 3'b010;
        d0 = drain_cyc; r0 = req_cyc;
        i_interrupt = 1;
        for (int i = 0; i < 5; i++) tick();
        i_exm_busy = 0;
        wait_load(k);
        check("wait_latency", k + 5, 21);
        check("wait_drain_cycles", drain_cyc - d0, 4);
        check("wait_req_cycles", req_cyc - r0, 15);
        check("wait_unstable", unstable, 0);
        check("wait_stall_drop", stall_drop, 0);
        check("wait_writes", {wlog[0], wlog[1], wlog[2]}, 96'h07FF_1234_07FE_5678_07FD_0002);
        check("wait_pc", o_pc_value, 32'h0000_0100);
        wait_n = 0; i_interrupt = 0;
        tick();

        // simultaneous edge and RTI: RTI first
        wlog.delete();
        i_ret_pc = 32'h0000_0ABC; i_flags = 3'b001;
        i_interrupt = 1; i_rti = 1;
        tick();
        i_rti = 0;
        wait_load(k);
        check("sim_rti_latency", k + 1, 5);
        check("sim_rti_first", {o_flags_load, o_int_ack, o_flags_value}, 5'b10_010);
        check("sim_rti_pc", o_pc_value, 32'h1234_5678);
        tick(); tick(); tick();
        i_interrupt = 0;
        tick();
        i_interrupt = 1; i_rti = 1;
        tick();
        i_rti = 0;
        wait_load(k);
        check("sim_entry_latency", k + 5, 8);
        check("sim_entry_ack", o_int_ack, 1);
        check("sim_entry_writes", {wlog[0], wlog[1], wlog[2]}, 96'h07FF_0000_07FE_0ABC_07FD_0001);
        wait_load(k);
        check("sim_rti2_latency", k, 6);
        check("sim_rti2", {o_flags_load, o_int_ack, o_flags_value}, 5'b10_001);
        check("sim_rti2_pc", o_pc_value, 32'h0000_0ABC);
        i_interrupt = 0;
        wait_load(k);
        check("sim_entry2_latency", k, 8);
        check("sim_entry2_ack", o_int_ack, 1);
        check("sim_entry2_sp", sp, 11'h7FC);
        tick();

        // reset during PUSH_LO
        i_ret_pc = 32'h0000_0ABC;
        i_interrupt = 1;
        for (int i = 0; i < 4; i++) tick();
        check("mid_push_lo", {bus.o_mem_req, bus.o_mem_we, bus.o_mem_addr, bus.o_mem_wdata},
              {2'b11, 11'h7FB, 16'h0ABC});
        i_interrupt = 0;
        #1 rst_n = 0;
        #1;
        check("mid_rst_ctl", {o_busy, o_stall, o_flush, bus.o_mem_req, bus.o_mem_we, o_sp_wr,
                              o_pc_load, o_flags_load, o_int_ack}, 0);
        check("mid_rst_data", {bus.o_mem_addr, bus.o_mem_wdata, o_sp_next, o_flags_value}, 0);
        check("mid_rst_pc", o_pc_value, 0);
        tick(); tick();
        rst_n = 1;
        l0 = loads;
        for (int i = 0; i < 15; i++) tick();
        check("post_rst_loads", loads - l0, 0);
        check("post_rst_busy", o_busy, 0);

        // SP wrap
        wlog.delete();
        sp = 11'h001;
        i_ret_pc = 32'hDEAD_BEEF; i_flags = 3'b110;
        i_interrupt = 1;
        wait_load(k);
        check("wrap_latency", k, 8);
        check("wrap_writes", {wlog[0], wlog[1], wlog[2]}, 96'h0001_DEAD_0000_BEEF_07FF_0006);
        check("wrap_sp", sp, 11'h7FE);
        check("wrap_pc", o_pc_value, 32'h0000_0100);
        i_interrupt = 0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/interrupt_sequencer.md
Name: interrupt_sequencer

Overview:
- Multi-cycle controller that sequences the pipelined CPU through interrupt entry and return-from-interrupt (RTI).
- Entry: freezes fetch/decode, drains execute-memory, pushes the 32-bit return PC and the flags onto the data-memory stack, reads a 32-bit handler vector, then redirects the PC.
- RTI: pops flags and PC in reverse order.
- Sits beside the hazard unit. Owns the data-memory port and the stack pointer only while it is busy.

Parameters:
ADDR_W, 11, data-memory word-address width (stack pointer width)
VECTOR_ADDR, 2, word address of handler vector low half; high half at VECTOR_ADDR+1

Ports:
i_clk  in  1  system clock, rising edge
i_reset  in  1  asynchronous, active-low reset
i_interrupt  in  1  external interrupt request level; rising edge sets pending
i_rti  in  1  one-cycle pulse: RTI instruction reached execute-memory
i_exm_busy  in  1  execute-memory holds branch/push/pop/memory op in flight
i_ret_pc  in  32  PC of oldest unexecuted instruction
i_flags  in  3  current {C,N,Z}
i_sp  in  ADDR_W  current stack pointer (points at next free word, grows down)
i_mem_ack  in  1  memory completed current request
i_mem_rdata  in  16  read data, valid when i_mem_ack=1 and o_mem_we=0
o_busy  out  1  sequencer not IDLE
o_stall  out  1  hold fetch, fetch/decode and decode/exm buffers
o_flush  out  1  clear fetch/decode and decode/exm buffers
o_mem_req  out  1  memory request
o_mem_we  out  1  1=write, 0=read
o_mem_addr  out  ADDR_W  request address
o_mem_wdata  out  16  write data
o_sp_wr  out  1  one-cycle pulse: stack pointer <= o_sp_next
o_sp_next  out  ADDR_W  new stack pointer value
o_pc_load  out  1  one-cycle pulse: PC <= o_pc_value
o_pc_value  out  32  redirect target
o_flags_load  out  1  one-cycle pulse: flags <= o_flags_value
o_flags_value  out  3  restored {C,N,Z}
o_int_ack  out  1  one-cycle pulse when handler PC is loaded

Behaviour:
- Reset (i_reset=0, asynchronous):
  - State=IDLE; pending, rti_req and capture registers are cleared.
  - Every output is 0.
  - Reset in mid-sequence abandons the sequence. Memory must tolerate o_mem_req dropping without ack.
- Request capture:
  - pending is set on a registered rising edge of i_interrupt.
  - rti_req is set on i_rti=1.
  - A new edge while a sequence runs stays pending and is serviced after return to IDLE.
- States:
  - IDLE -> DRAIN when rti_req or pending. If both are set, rti_req wins and pending is kept.
  - DRAIN: o_stall=1 and o_flush=1 every cycle. Exit after at least one cycle, once i_exm_busy=0.
    - On exit, capture i_ret_pc and i_flags.
    - Clear the request being served.
    - Go to PUSH_HI (interrupt) or POP_FLAGS (RTI).
  - Interrupt path: PUSH_HI (wdata=pc[31:16]) -> PUSH_LO (pc[15:0]) -> PUSH_FLAGS ({13'b0,flags}) -> VEC_LO (read VECTOR_ADDR) -> VEC_HI (read VECTOR_ADDR+1) -> LOAD -> IDLE.
  - RTI path: POP_FLAGS -> POP_LO -> POP_HI -> RLOAD -> IDLE.
- Memory handshake (every memory state):
  - o_mem_req=1, with we/addr/wdata held stable until the cycle where i_mem_ack=1.
  - The state advances on the next edge. Zero wait states means 1 cycle per access.
- Push: addr=i_sp. On ack, o_sp_wr=1 and o_sp_next=i_sp-1.
- Pop: addr=i_sp+1. On ack, o_sp_wr=1 and o_sp_next=i_sp+1; capture rdata.
- Vector reads do not touch SP.
- SP arithmetic wraps modulo 2^ADDR_W.
- Captured data:
  - Read data from POP_FLAGS keeps bits [2:0] only.
  - POP_LO and VEC_LO fill pc[15:0]; POP_HI and VEC_HI fill pc[31:16].
- LOAD: o_pc_load=1, o_int_ack=1, o_flush=1 for exactly one cycle. o_pc_value = vector.
- RLOAD: o_pc_load=1, o_flags_load=1, o_flush=1 for exactly one cycle. o_pc_value/o_flags_value = popped values.
- o_stall=1 and o_busy=1 in every state except IDLE. o_pc_value/o_flags_value are held until the next load.
- Latency:
  - Interrupt with zero-wait memory and no drain wait: edge to o_pc_load = 8 cycles (edge reg, DRAIN, 5 accesses, LOAD).
  - RTI: 5 cycles from i_rti.

Test Plan:
- Entry: sp=0x7FF, ret_pc=0x0001_0040, flags=3'b101, mem[2]=0x0100, mem[3]=0x0000, zero-wait -> writes 0x0001@0x7FF, 0x0040@0x7FE, 0x0005@0x7FD; final sp=0x7FC; o_pc_load with 0x0000_0100 and o_int_ack 8 cycles after edge.
- RTI after entry: i_rti pulse with sp=0x7FC -> reads 0x7FD, 0x7FE, 0x7FF; o_flags_load 3'b101 and o_pc_load 0x0001_0040 in the same cycle; sp back to 0x7FF.
- Drain and wait states: i_exm_busy=1 for 3 cycles and i_mem_ack delayed 2 cycles per access -> DRAIN lasts 4 cycles; each access lasts 3 cycles; req/addr/wdata stable throughout; o_stall never drops.
- Simultaneous: interrupt edge in the same cycle as i_rti -> RTI sequence completes first, then the interrupt entry starts with no intervening IDLE work lost; a second edge during entry is serviced after a subsequent RTI.
- Reset mid-sequence: i_reset=0 during PUSH_LO -> all outputs 0 immediately (asynchronous), state IDLE, pending cleared; no o_pc_load after release.
- Wrap: sp=0x001 at entry -> pushes to 0x001, 0x000, 0x7FF; final sp=0x7FE.
